// File: rtl/prach_pkg.sv
// Shared PRACH definitions: channel/sample widths, sample and channel types,
// and the sample-store entry layout used by the HB5 polyphase demultiplexer.
package prach_pkg;

    localparam int NumChannel     = 256;
    localparam int NumChannelUsed = 48;
    localparam int SampleW        = 16;
    localparam int ChnW           = 8;

    typedef logic signed [SampleW-1:0] sample_t;
    typedef logic        [ChnW-1:0]    chn_t;

    // One sample-store word: the phase-0 sample plus its frame-start flag.
    typedef struct packed {
        logic    sync;
        sample_t dq;
    } entry_t;

    localparam int StoreW = $bits(entry_t);

endpackage

// File: rtl/prach_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read.
// A read of an address written on the same edge returns the old contents.
module prach_sdp_ram #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/prach_hb5_dmx.sv
// Polyphase demultiplexer ahead of HB5: pairs consecutive samples per TDM channel.
// Define PRACH_HB5_DMX_CHN_FILTER_EN to ignore beats on channels >= NUM_CHANNEL_USED.
module prach_hb5_dmx
    import prach_pkg::*;
#(
    parameter int NUM_CHANNEL      = NumChannel,
    parameter int NUM_CHANNEL_USED = NumChannelUsed
) (
    input  logic    clk,
    input  logic    rst,
    input  sample_t din_dq,
    input  logic    din_dv,
    input  chn_t    din_chn,
    input  logic    sync_in,
    output sample_t dout_dp1,
    output sample_t dout_dp2,
    output logic    dout_dv,
    output chn_t    dout_chn,
    output logic    sync_out
);

    localparam int AW = $clog2(NUM_CHANNEL);
    typedef logic [AW-1:0] addr_t;

    // Stage A: registered input beat, aligned with the RAM read data.
    logic    a_dv_q;
    sample_t a_dq_q;
    chn_t    a_chn_q;
    logic    a_sync_q;
    logic    fwd_hit_q;
    entry_t  fwd_data_q;

    // Stage B: assembled pair.
    logic    b_dv_q;
    sample_t b_dp1_q;
    sample_t b_dp2_q;
    chn_t    b_chn_q;
    logic    b_sync_q;

    // Output registers.
    logic    out_dv_q;
    sample_t out_dp1_q;
    sample_t out_dp2_q;
    chn_t    out_chn_q;
    logic    out_sync_q;

    logic [NUM_CHANNEL-1:0] ph_q;
    logic [NUM_CHANNEL-1:0] ph_d;

    addr_t              a_addr;
    addr_t              din_addr;
    logic               clear_all;
    logic               ph_cur;
    logic               chn_ok;
    logic               in_used;
    logic               accept;
    logic               wr_en;
    logic               pair_en;
    entry_t             wr_entry;
    entry_t             stored;
    logic [StoreW-1:0]  ram_rd_data;

    assign a_addr   = a_chn_q[AW-1:0];
    assign din_addr = din_chn[AW-1:0];
    assign in_used  = (int'(a_chn_q) < NUM_CHANNEL_USED);

`ifdef PRACH_HB5_DMX_CHN_FILTER_EN
    assign chn_ok = in_used;
`else
    logic unused_in_used;
    assign unused_in_used = in_used;
    assign chn_ok         = 1'b1;
`endif

    // A qualified sync wipes every phase before its own beat is classified,
    // so the sync beat is always the first half of a pair.
    assign clear_all = a_dv_q & a_sync_q;
    assign ph_cur    = ph_q[a_addr] & ~clear_all;
    assign accept    = a_dv_q & chn_ok;
    assign wr_en     = accept & ~ph_cur;
    assign pair_en   = accept & ph_cur;

    assign wr_entry.sync = a_sync_q;
    assign wr_entry.dq   = a_dq_q;

    // Back-to-back beats on one channel: the RAM read for the second beat is
    // launched on the same edge that commits the first beat's write.
    assign stored = fwd_hit_q ? fwd_data_q : entry_t'(ram_rd_data);

    always_comb begin
        ph_d = ph_q;
        if (clear_all) begin
            ph_d = '0;
        end
        if (accept) begin
            ph_d[a_addr] = ~ph_cur;
        end
    end

    prach_sdp_ram #(
        .WIDTH (StoreW),
        .DEPTH (NUM_CHANNEL),
        .AW    (AW)
    ) u_store (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (a_addr),
        .wr_data_i (wr_entry),
        .rd_en_i   (din_dv),
        .rd_addr_i (din_addr),
        .rd_data_o (ram_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_dv_q     <= 1'b0;
            a_dq_q     <= '0;
            a_chn_q    <= '0;
            a_sync_q   <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            ph_q       <= '0;
        end else begin
            a_dv_q     <= din_dv;
            a_dq_q     <= din_dq;
            a_chn_q    <= din_chn;
            a_sync_q   <= sync_in;
            fwd_hit_q  <= wr_en && (din_addr == a_addr);
            fwd_data_q <= wr_entry;
            ph_q       <= ph_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_dv_q   <= 1'b0;
            b_dp1_q  <= '0;
            b_dp2_q  <= '0;
            b_chn_q  <= '0;
            b_sync_q <= 1'b0;
        end else begin
            b_dv_q <= pair_en;
            if (pair_en) begin
                b_dp1_q  <= a_dq_q;
                b_dp2_q  <= stored.dq;
                b_chn_q  <= a_chn_q;
                b_sync_q <= stored.sync;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_dv_q   <= 1'b0;
            out_dp1_q  <= '0;
            out_dp2_q  <= '0;
            out_chn_q  <= '0;
            out_sync_q <= 1'b0;
        end else begin
            out_dv_q   <= b_dv_q;
            out_sync_q <= b_dv_q & b_sync_q;
            if (b_dv_q) begin
                out_dp1_q <= b_dp1_q;
                out_dp2_q <= b_dp2_q;
                out_chn_q <= b_chn_q;
            end
        end
    end

    assign dout_dv  = out_dv_q;
    assign dout_dp1 = out_dp1_q;
    assign dout_dp2 = out_dp2_q;
    assign dout_chn = out_chn_q;
    assign sync_out = out_sync_q;

endmodule

// File: tb/tb_prach_hb5_dmx.sv
// Directed bench for prach_hb5_dmx: hand-computed pairs queued per step,
// checked by a negedge monitor; exact latency and reset behaviour checked inline.
module tb_prach_hb5_dmx;
    import prach_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    sample_t din_dq;
    logic    din_dv;
    chn_t    din_chn;
    logic    sync_in;
    sample_t dout_dp1;
    sample_t dout_dp2;
    logic    dout_dv;
    chn_t    dout_chn;
    logic    sync_out;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pairs = 0;

    typedef struct {
        chn_t    chn;
        sample_t dp2;
        sample_t dp1;
        logic    sync;
    } exp_t;

    exp_t exp_q[$];

    prach_hb5_dmx dut (
        .clk      (clk),
        .rst      (rst),
        .din_dq   (din_dq),
        .din_dv   (din_dv),
        .din_chn  (din_chn),
        .sync_in  (sync_in),
        .dout_dp1 (dout_dp1),
        .dout_dp2 (dout_dp2),
        .dout_dv  (dout_dv),
        .dout_chn (dout_chn),
        .sync_out (sync_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input int c, input int dp2, input int dp1, input bit s);
        exp_t e;
        e.chn  = chn_t'(c);
        e.dp2  = sample_t'(dp2);
        e.dp1  = sample_t'(dp1);
        e.sync = s;
        exp_q.push_back(e);
    endtask

    task automatic beat(input int c, input int v, input bit s);
        @(negedge clk);
        din_dv  = 1'b1;
        din_chn = chn_t'(c);
        din_dq  = sample_t'(v);
        sync_in = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_dv  = 1'b0;
            sync_in = 1'b0;
        end
    endtask

    // Every output pair is matched, in order, against the expected queue.
    always @(negedge clk) begin
        if (!rst && dout_dv) begin
            exp_t e;
            n_pairs++;
            $display("pair chn=%0d dp2=%0d dp1=%0d sync=%0b", dout_chn, dout_dp2, dout_dp1, sync_out);
            if (exp_q.size() == 0) begin
                chk("unexpected_dv_chn", int'(dout_chn), -1);
            end else begin
                e = exp_q.pop_front();
                chk("pair_chn",  int'(dout_chn), int'(e.chn));
                chk("pair_dp2",  int'(dout_dp2), int'(e.dp2));
                chk("pair_dp1",  int'(dout_dp1), int'(e.dp1));
                chk("pair_sync", int'(sync_out), int'(e.sync));
            end
        end else if (sync_out) begin
            chk("sync_without_dv", int'(sync_out), 0);
        end
    end

    initial begin
        int base;
        rst     = 1'b1;
        din_dv  = 1'b0;
        din_chn = '0;
        din_dq  = '0;
        sync_in = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dv",   int'(dout_dv),  0);
        chk("rst_sync", int'(sync_out), 0);
        chk("rst_dp1",  int'(dout_dp1), 0);
        chk("rst_dp2",  int'(dout_dp2), 0);
        chk("rst_chn",  int'(dout_chn), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Single pair on channel 5 with exact two-cycle latency
        beat(5, 100, 0);
        push_exp(5, 100, 200, 0);
        beat(5, 200, 0);
        @(posedge clk);
        @(negedge clk);
        din_dv = 1'b0;
        @(posedge clk);
        #1;
        chk("lat_t1_dv", int'(dout_dv), 0);
        @(posedge clk);
        #1;
        chk("lat_t2_dv",  int'(dout_dv),  1);
        chk("lat_t2_dp2", int'(dout_dp2), 100);
        chk("lat_t2_dp1", int'(dout_dp1), 200);
        chk("lat_t2_chn", int'(dout_chn), 5);
        idle(4);
        chk("t1_drain", exp_q.size(), 0);

        // Two interleaved rounds over channels 0..47 with random idle gaps
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 48; c++) begin
                if (r == 1) push_exp(c, c, c + 1000, 0);
                beat(c, (r == 1) ? c + 1000 : c, 0);
                idle($urandom_range(0, 2));
            end
        end
        idle(6);
        chk("t2_drain", exp_q.size(), 0);

        // Sync drops chn 3's lone sample and flags only chn 0's first pair
        beat(3, 7, 0);
        beat(0, 10, 1);
        push_exp(0, 10, 11, 1);
        beat(0, 11, 0);
        beat(3, 8, 0);
        push_exp(3, 8, 9, 0);
        beat(3, 9, 0);
        beat(0, 12, 0);
        push_exp(0, 12, 13, 0);
        beat(0, 13, 0);
        idle(6);
        chk("t3_drain", exp_q.size(), 0);

        // Reset right after a phase-1 beat of chn 9 discards the pair
        beat(9, 50, 0);
        beat(9, 51, 0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        din_dv = 1'b0;
        #1;
        chk("midrst_dv",   int'(dout_dv),  0);
        chk("midrst_sync", int'(sync_out), 0);
        chk("midrst_dp1",  int'(dout_dp1), 0);
        chk("midrst_dp2",  int'(dout_dp2), 0);
        chk("midrst_chn",  int'(dout_chn), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        beat(9, 60, 0);
        push_exp(9, 60, 61, 0);
        beat(9, 61, 0);
        idle(6);
        chk("t4_drain", exp_q.size(), 0);

        // Channels outside the used range
`ifndef PRACH_HB5_DMX_CHN_FILTER_EN
        push_exp(48, 1, 2, 0);
        push_exp(255, 3, 4, 0);
`endif
        beat(48, 1, 0);
        beat(48, 2, 0);
        beat(255, 3, 0);
        beat(255, 4, 0);
        idle(6);
        chk("t5_drain", exp_q.size(), 0);

        // Full-rate 256-channel stream, four rounds, sync on the first beat
        base = n_pairs;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 256; c++) begin
                if (r % 2 == 1) push_exp(c, (r - 1) * 4096 + c, r * 4096 + c, (r == 1) && (c == 0));
                beat(c, r * 4096 + c, (r == 0) && (c == 0));
            end
        end
        idle(6);
        chk("t6_drain", exp_q.size(), 0);
        chk("t6_pair_count", n_pairs - base, 512);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
